// File: rtl/multicycle_alu.sv
// multicycle_alu: registered ALU with valid/ready handshakes on both sides.
// Single-cycle ops finish one cycle after accept. MUL/MULHU/DIVU/REMU are
// iterative, one bit per cycle. Only one operation is in flight at a time.
module multicycle_alu #(
    parameter int unsigned WIDTH         = 32,
    parameter int unsigned ENABLE_MULDIV = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] i1,
    input  logic [WIDTH-1:0] i2,
    input  logic [3:0]       sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             zero_flag,
    output logic             negative_flag,
    output logic             carry_flag,
    output logic             overflow_flag
);

    localparam int unsigned SHW       = $clog2(WIDTH);
    localparam int unsigned REP       = (WIDTH + 31) / 32;
    localparam bit          MULDIV_ON = (ENABLE_MULDIV != 0);

    localparam logic [REP*32-1:0] DEAD_FILL = {REP{32'hDEAD_BEEF}};
    localparam logic [WIDTH-1:0]  UNDEF_VAL = DEAD_FILL[WIDTH-1:0];
    localparam logic [SHW:0]      CNT_LOAD  = (SHW+1)'(WIDTH);
    localparam logic [SHW:0]      CNT_ONE   = (SHW+1)'(1);

    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_SUB   = 4'b0001;
    localparam logic [3:0] OP_AND   = 4'b0010;
    localparam logic [3:0] OP_OR    = 4'b0011;
    localparam logic [3:0] OP_XOR   = 4'b0100;
    localparam logic [3:0] OP_NOT   = 4'b0101;
    localparam logic [3:0] OP_SLL   = 4'b0110;
    localparam logic [3:0] OP_SRL   = 4'b0111;
    localparam logic [3:0] OP_SRA   = 4'b1000;
    localparam logic [3:0] OP_MUL   = 4'b1001;
    localparam logic [3:0] OP_MULHU = 4'b1010;
    localparam logic [3:0] OP_DIVU  = 4'b1011;
    localparam logic [3:0] OP_REMU  = 4'b1100;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t state, state_next;

    logic             accept;
    logic             is_mul;
    logic             is_md;
    logic             go_busy;

    // captured operation and iterative datapath registers
    logic [3:0]       op_q;
    logic [WIDTH-1:0] hi_q, lo_q, b_q;
    logic [SHW:0]     count_q;

    // registered outputs
    logic [WIDTH-1:0] out_q;
    logic             zero_q, neg_q, carry_q, ovf_q;

    // single-cycle datapath
    logic [SHW-1:0]   shamt;
    logic [WIDTH:0]   sum, diff;
    logic [WIDTH-1:0] sll_t, srl_t;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c, alu_v;

    // iterative step datapath
    logic [WIDTH:0]   mul_s;
    logic [WIDTH:0]   rem_sh, trial;
    logic [WIDTH-1:0] hi_n, lo_n, md_res;
    logic             md_is_mul;

    assign accept  = in_valid & in_ready;
    assign is_mul  = (sel == OP_MUL) || (sel == OP_MULHU);
    assign is_md   = MULDIV_ON && (is_mul || (sel == OP_DIVU) || (sel == OP_REMU));
    // division by zero has a fixed answer, so it completes in one cycle
    assign go_busy = is_md && (is_mul || (i2 != '0));

    assign out           = out_q;
    assign zero_flag     = zero_q;
    assign negative_flag = neg_q;
    assign carry_flag    = carry_q;
    assign overflow_flag = ovf_q;

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    // next-state decode
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (accept) state_next = go_busy ? S_BUSY : S_DONE;
            S_BUSY:  if (count_q == CNT_ONE) state_next = S_DONE;
            S_DONE:  if (out_ready) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // handshake outputs
    always_comb begin
        in_ready  = (state == S_IDLE) & ~rst;
        out_valid = (state == S_DONE);
    end

    // single-cycle result and flags, evaluated on the live inputs at accept
    always_comb begin
        shamt   = i2[SHW-1:0];
        sum     = {1'b0, i1} + {1'b0, i2};
        diff    = {1'b0, i1} - {1'b0, i2};
        sll_t   = i1 << (shamt - SHW'(1));
        srl_t   = i1 >> (shamt - SHW'(1));
        alu_res = UNDEF_VAL;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (sel)
            OP_ADD: begin
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                alu_v   = (i1[WIDTH-1] == i2[WIDTH-1]) && (sum[WIDTH-1] != i1[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = diff[WIDTH-1:0];
                alu_c   = diff[WIDTH];
                alu_v   = (i1[WIDTH-1] != i2[WIDTH-1]) && (diff[WIDTH-1] != i1[WIDTH-1]);
            end
            OP_AND:  alu_res = i1 & i2;
            OP_OR:   alu_res = i1 | i2;
            OP_XOR:  alu_res = i1 ^ i2;
            OP_NOT:  alu_res = ~i1;
            OP_SLL: begin
                alu_res = i1 << shamt;
                alu_c   = (shamt != '0) && sll_t[WIDTH-1];
            end
            OP_SRL: begin
                alu_res = i1 >> shamt;
                alu_c   = (shamt != '0) && srl_t[0];
            end
            OP_SRA: begin
                alu_res = WIDTH'($signed(i1) >>> shamt);
                alu_c   = (shamt != '0) && srl_t[0];
            end
            // with mul/div enabled, MUL/MULHU always go iterative and this value is unused
            OP_MUL, OP_MULHU: alu_res = UNDEF_VAL;
            OP_DIVU: alu_res = MULDIV_ON ? '1 : UNDEF_VAL;
            OP_REMU: alu_res = MULDIV_ON ? i1 : UNDEF_VAL;
            default: alu_res = UNDEF_VAL;
        endcase
    end

    // one shift-add (mul) or restoring-subtract (div) step on the held registers
    always_comb begin
        md_is_mul = (op_q == OP_MUL) || (op_q == OP_MULHU);
        // mul: {hi,lo} holds partial product above the remaining multiplier bits
        mul_s     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
        // div: hi is the partial remainder, lo shifts dividend out and quotient in
        rem_sh    = {hi_q, lo_q[WIDTH-1]};
        trial     = rem_sh - {1'b0, b_q};
        if (md_is_mul) begin
            hi_n = mul_s[WIDTH:1];
            lo_n = {mul_s[0], lo_q[WIDTH-1:1]};
        end else if (!trial[WIDTH]) begin
            hi_n = trial[WIDTH-1:0];
            lo_n = {lo_q[WIDTH-2:0], 1'b1};
        end else begin
            hi_n = rem_sh[WIDTH-1:0];
            lo_n = {lo_q[WIDTH-2:0], 1'b0};
        end
        case (op_q)
            OP_MULHU, OP_REMU: md_res = hi_n;
            default:           md_res = lo_n;
        endcase
    end

    // operand capture, iteration and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q    <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            b_q     <= '0;
            count_q <= '0;
            out_q   <= '0;
            zero_q  <= 1'b0;
            neg_q   <= 1'b0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (accept) begin
            op_q <= sel;
            if (go_busy) begin
                count_q <= CNT_LOAD;
                hi_q    <= '0;
                lo_q    <= is_mul ? i2 : i1;
                b_q     <= is_mul ? i1 : i2;
            end else begin
                out_q   <= alu_res;
                zero_q  <= (alu_res == '0);
                neg_q   <= alu_res[WIDTH-1];
                carry_q <= alu_c;
                ovf_q   <= alu_v;
            end
        end else if (state == S_BUSY) begin
            hi_q    <= hi_n;
            lo_q    <= lo_n;
            count_q <= count_q - (SHW+1)'(1);
            if (count_q == CNT_ONE) begin
                out_q   <= md_res;
                zero_q  <= (md_res == '0);
                neg_q   <= md_res[WIDTH-1];
                carry_q <= 1'b0;
                ovf_q   <= 1'b0;
            end
        end
    end

endmodule
